// File: rtl/mux32bit_3to1.sv
// Three-input word mux with a registered copy and invalid-select diagnostics.
// Optional MUX3_HOLD_INVALID_EN: y_q holds its previous value when sel==3.
module mux32bit_3to1 #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] INV_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_q,
   output logic             sel_err,
   output logic             err_sticky
);

   logic invalid;

   assign invalid = (sel == 2'd3);

   // An unknown select falls through to the default so simulation shows X on y.
   always_comb begin
      y = INV_VALUE;
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         2'd3:    y = INV_VALUE;
         default: y = 'x;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q        <= '0;
         sel_err    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
`ifdef MUX3_HOLD_INVALID_EN
         if (!invalid) begin
            y_q <= y;
         end
`else
         y_q <= y;
`endif
         sel_err    <= invalid;
         err_sticky <= err_sticky | invalid;
      end
   end

endmodule

// File: tb/tb_mux32bit_3to1.sv
// Directed-vector bench for mux32bit_3to1; expectations follow the
// MUX3_HOLD_INVALID_EN setting of the build.
module tb_mux32bit_3to1;

   logic        clk;
   logic        reset;
   logic [31:0] d0;
   logic [31:0] d1;
   logic [31:0] d2;
   logic [1:0]  sel;
   logic [31:0] y;
   logic [31:0] y_q;
   logic        sel_err;
   logic        err_sticky;

   int vectors_applied = 0;
   int miscompares     = 0;

   mux32bit_3to1 dut (
      .clk        (clk),
      .reset      (reset),
      .d0         (d0),
      .d1         (d1),
      .d2         (d2),
      .sel        (sel),
      .y          (y),
      .y_q        (y_q),
      .sel_err    (sel_err),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors_applied++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [1:0] s);
      d0  = a;
      d1  = b;
      d2  = c;
      sel = s;
      #1;
   endtask

   task automatic nextEdge();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] hold_expect;

   initial begin
      reset = 1'b1;
      d0 = '0; d1 = '0; d2 = '0; sel = 2'd0;
      nextEdge();
      nextEdge();
      checkOutput("reset_y_q", y_q, 32'h0);
      checkOutput("reset_sel_err", {31'b0, sel_err}, 32'h0);
      checkOutput("reset_sticky", {31'b0, err_sticky}, 32'h0);

      @(negedge clk);
      reset = 1'b0;
      applyStimulus(32'h1100, 32'h001A, 32'h001A, 2'd1);
      checkOutput("sel1_y", y, 32'h0000001A);
      nextEdge();
      checkOutput("sel1_y_q", y_q, 32'h0000001A);
      checkOutput("sel1_sel_err", {31'b0, sel_err}, 32'h0);

      @(negedge clk);
      applyStimulus(32'hFFFF, 32'h8976, 32'h1842, 2'd0);
      checkOutput("sel0_y", y, 32'h0000FFFF);
      nextEdge();
      checkOutput("sel0_y_q", y_q, 32'h0000FFFF);
      @(negedge clk);
      applyStimulus(32'hFFFF, 32'h8976, 32'h1467, 2'd2);
      checkOutput("sel2_y", y, 32'h00001467);
      nextEdge();
      checkOutput("sel2_y_q", y_q, 32'h00001467);

      // Three select changes inside one clock phase: y must track each.
      @(negedge clk);
      applyStimulus(32'h1111, 32'hABCD, 32'h2396, 2'd1);
      checkOutput("seq_a_y", y, 32'h0000ABCD);
      applyStimulus(32'h2345, 32'h5432, 32'h6890, 2'd2);
      checkOutput("seq_b_y", y, 32'h00006890);
      applyStimulus(32'h7777, 32'h4444, 32'hEEEE, 2'd0);
      checkOutput("seq_c_y", y, 32'h00007777);
      nextEdge();
      checkOutput("seq_y_q", y_q, 32'h00007777);

      @(negedge clk);
      applyStimulus(32'h2345, 32'h5432, 32'h6890, 2'd1);
      nextEdge();
      checkOutput("pre_inv_y_q", y_q, 32'h00005432);

      @(negedge clk);
      applyStimulus(32'hAAAA, 32'hAAAA, 32'hAAAA, 2'd3);
      checkOutput("inv_y", y, 32'h0);
      nextEdge();
`ifdef MUX3_HOLD_INVALID_EN
      hold_expect = 32'h00005432;
`else
      hold_expect = 32'h0;
`endif
      checkOutput("inv_y_q", y_q, hold_expect);
      checkOutput("inv_sel_err", {31'b0, sel_err}, 32'h1);
      checkOutput("inv_sticky", {31'b0, err_sticky}, 32'h1);

      @(negedge clk);
      applyStimulus(32'hEEEE, 32'h0, 32'h0, 2'd0);
      checkOutput("recover_y", y, 32'h0000EEEE);
      nextEdge();
      checkOutput("recover_y_q", y_q, 32'h0000EEEE);
      checkOutput("recover_sel_err", {31'b0, sel_err}, 32'h0);
      checkOutput("recover_sticky", {31'b0, err_sticky}, 32'h1);

      // Mid-stream reset, with an invalid select present to prove reset priority.
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(32'h1234, 32'h0, 32'h0, 2'd0);
      checkOutput("rst_y_passthru", y, 32'h00001234);
      nextEdge();
      checkOutput("rst_y_q", y_q, 32'h0);
      checkOutput("rst_sel_err", {31'b0, sel_err}, 32'h0);
      checkOutput("rst_sticky", {31'b0, err_sticky}, 32'h0);
      @(negedge clk);
      applyStimulus(32'h1234, 32'h0, 32'h0, 2'd3);
      nextEdge();
      checkOutput("rst_inv_sel_err", {31'b0, sel_err}, 32'h0);
      checkOutput("rst_inv_sticky", {31'b0, err_sticky}, 32'h0);

      @(negedge clk);
      reset = 1'b0;
      applyStimulus(32'h0, 32'h0, 32'hCAFE, 2'd2);
      checkOutput("post_rst_y", y, 32'h0000CAFE);
      nextEdge();
      checkOutput("post_rst_y_q", y_q, 32'h0000CAFE);
      checkOutput("post_rst_sticky", {31'b0, err_sticky}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
